l2_arbiter: RTL
===============

Name: l2_arbiter

Overview:
Two-client arbiter that shares the single L2 cache line port between the L1 I-cache and the L1 D-cache. It accepts whole-line read/write requests, selects one client with round-robin priority, and latches that client's address, data and opcode. It drives the L2 port from those latched registers and routes the L2 response back to the granted client only. It sits between the two L1 caches and the L2 cache, whose datapath contains the 16-way line-select muxes.

Parameters:
ADDR_W, 32, request address width in bits
LINE_W, 256, cache line width in bits

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
i_read  in  1  I-cache line read request, held until i_resp
i_address  in  ADDR_W  I-cache request address
i_resp  out  1  one-cycle completion pulse to I-cache
i_rdata  out  LINE_W  read line returned to I-cache
d_read  in  1  D-cache line read request, held until d_resp
d_write  in  1  D-cache line write request, held until d_resp
d_address  in  ADDR_W  D-cache request address
d_wdata  in  LINE_W  D-cache write line
d_resp  out  1  one-cycle completion pulse to D-cache
d_rdata  out  LINE_W  read line returned to D-cache
l2_read  out  1  read request to L2
l2_write  out  1  write request to L2
l2_address  out  ADDR_W  L2 request address
l2_wdata  out  LINE_W  L2 write line
l2_resp  in  1  L2 completion, one-cycle pulse
l2_rdata  in  LINE_W  L2 read line, valid when l2_resp=1

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; l2_read=0, l2_write=0, i_resp=0, d_resp=0; l2_address, l2_wdata, i_rdata, d_rdata=0; last_grant=I, which gives D priority on the first tie.
- Reset is synchronous and takes priority over every other event. Reset in BUSY drops the L2 request at that edge and discards the transaction; no resp pulse is issued.
- FSM states: IDLE, BUSY, DONE. All outputs are registered.
- IDLE:
  - req_i = i_read; req_d = d_read | d_write.
  - Neither request: stay in IDLE.
  - One request: grant that client.
  - Both requests: grant the client that is not last_grant.
  - On grant at edge t: latch address, wdata (D only) and op; set last_grant; go to BUSY.
  - l2_read/l2_write assert from cycle t+1.
- D-side opcode: d_read=1 and d_write=1 together is illegal; write wins. I-side op is always read; l2_wdata is held at its previous value for I grants.
- BUSY:
  - l2_read/l2_write/l2_address/l2_wdata stay stable while waiting, independent of client inputs.
  - On edge with l2_resp=1: deassert l2_read/l2_write; register l2_rdata into the granted client's rdata (reads only; writes leave rdata unchanged); pulse the granted client's resp for exactly one cycle; go to DONE.
  - The non-granted client's resp and rdata are untouched.
- DONE: one bubble cycle, resp=0, no L2 request, so the served client can drop its request. Then go to IDLE.
- Timing: minimum request-to-resp latency is L2 latency + 2 cycles.
- A served client re-requesting immediately is seen in IDLE at the earliest 2 cycles after its resp. A waiting opposite client is granted at that same IDLE edge.
- l2_resp while in IDLE or DONE is ignored.
- A client deasserting its request mid-BUSY (protocol violation): the transaction still completes and the resp pulse is still issued.
- Round-robin guarantee: a continuously requesting client waits at most one other transaction.
- Widths are fixed by parameters; no truncation or extension is performed.

Test Plan:
- Single I read: i_read=1, i_address=0x0000_1240; L2 model responds 3 cycles after l2_read with l2_rdata=0xA5..A5 -> l2_read=1 with l2_address=0x0000_1240 from cycle 1; i_resp=1 for one cycle with i_rdata=0xA5..A5; d_resp stays 0.
- Single D write: d_write=1, d_address=0x0000_8000, d_wdata=0x1234..5678 -> l2_write=1, l2_read=0, l2_wdata=0x1234..5678; d_resp pulses once; d_rdata unchanged.
- Simultaneous after reset: i_read and d_read both asserted and held -> D is served first, then I. Repeat with both re-asserted: grants alternate D, I, D, I.
- Back-to-back starvation check: D requests continuously while I requests once -> I is granted right after the current D transaction completes. No two consecutive D grants occur while I is pending.
- Reset in BUSY: assert rst for one cycle while l2_read=1 -> l2_read=0 after that edge, no resp pulse, state IDLE. The next tie grants D first.
- Spurious and illegal inputs: l2_resp pulsed in IDLE -> no resp output and no state change. d_read=d_write=1 -> l2_write=1 and l2_read=0.

Source files
------------

// File: rtl/l2_arbiter.sv
// Two-client round-robin arbiter sharing the L2 line port between the L1 I-cache and D-cache.
// The granted request is latched and replayed to L2 from registers. The L2 response is steered
// back to the granted client only.
module l2_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic              l2_resp,
  input  logic [LINE_W-1:0] l2_rdata
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_d_q, last_d_d;   // 1: last grant went to D
  logic              sel_d_q, sel_d_d;     // 1: current transaction belongs to D
  logic              l2_read_q, l2_read_d;
  logic              l2_write_q, l2_write_d;
  logic [ADDR_W-1:0] l2_address_q, l2_address_d;
  logic [LINE_W-1:0] l2_wdata_q, l2_wdata_d;
  logic              i_resp_q, i_resp_d;
  logic              d_resp_q, d_resp_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;

  logic req_i, req_d, grant_d;

  // Arbitration: on a tie, grant whichever client was not served last.
  always_comb begin
    req_i   = i_read;
    req_d   = d_read | d_write;
    grant_d = req_d & (~req_i | ~last_d_q);
  end

  // Next-state and registered-output computation for the IDLE/BUSY/DONE sequence.
  always_comb begin
    state_d      = state_q;
    last_d_d     = last_d_q;
    sel_d_d      = sel_d_q;
    l2_read_d    = l2_read_q;
    l2_write_d   = l2_write_q;
    l2_address_d = l2_address_q;
    l2_wdata_d   = l2_wdata_q;
    i_resp_d     = 1'b0;
    d_resp_d     = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      StIdle: begin
        if (req_i || req_d) begin
          sel_d_d  = grant_d;
          last_d_d = grant_d;
          state_d  = StBusy;
          if (grant_d) begin
            // Simultaneous read and write is illegal; the write takes precedence.
            l2_address_d = d_address;
            l2_wdata_d   = d_wdata;
            l2_write_d   = d_write;
            l2_read_d    = ~d_write;
          end else begin
            l2_address_d = i_address;
            l2_read_d    = 1'b1;
            l2_write_d   = 1'b0;
          end
        end
      end
      StBusy: begin
        if (l2_resp) begin
          l2_read_d  = 1'b0;
          l2_write_d = 1'b0;
          state_d    = StDone;
          if (sel_d_q) begin
            d_resp_d = 1'b1;
            if (!l2_write_q) begin
              d_rdata_d = l2_rdata;
            end
          end else begin
            i_resp_d  = 1'b1;
            i_rdata_d = l2_rdata;
          end
        end
      end
      StDone: begin
        // Bubble cycle so the served client can withdraw its request.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset; reset discards any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_d_q     <= 1'b0;
      sel_d_q      <= 1'b0;
      l2_read_q    <= 1'b0;
      l2_write_q   <= 1'b0;
      l2_address_q <= '0;
      l2_wdata_q   <= '0;
      i_resp_q     <= 1'b0;
      d_resp_q     <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_d_q     <= last_d_d;
      sel_d_q      <= sel_d_d;
      l2_read_q    <= l2_read_d;
      l2_write_q   <= l2_write_d;
      l2_address_q <= l2_address_d;
      l2_wdata_q   <= l2_wdata_d;
      i_resp_q     <= i_resp_d;
      d_resp_q     <= d_resp_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign l2_read    = l2_read_q;
  assign l2_write   = l2_write_q;
  assign l2_address = l2_address_q;
  assign l2_wdata   = l2_wdata_q;
  assign i_resp     = i_resp_q;
  assign d_resp     = d_resp_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;

endmodule
